// File: rtl/hdc_pkg.sv
// Shared constants and types for the message tokenizer: buffer sizing,
// token code points and the collector state encoding.
package hdc_pkg;

  localparam int MAX_LENGTH  = 160;
  localparam int NUM_CHAR    = 37;
  localparam int TOK_W       = 6;

  localparam int TOK_OTHER   = 0;
  localparam int TOK_DIGIT0  = 1;
  localparam int TOK_ALPHA_A = 11;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/hdc_char_map.sv
// Combinational byte mapper: ASCII upper-case folded to lower-case, and the
// folded byte translated to a token index (digits, letters, everything else).
module hdc_char_map
  import hdc_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int TOKEN_W = 6
) (
  input  logic [CHAR_W-1:0]  ch,
  output logic [CHAR_W-1:0]  lc,
  output logic [TOKEN_W-1:0] tok
);

  always_comb begin
    lc = ch;
    if (ch >= CHAR_W'(65) && ch <= CHAR_W'(90)) begin
      lc = ch + CHAR_W'(32);
    end
    tok = TOKEN_W'(TOK_OTHER);
    // Letters are matched on the folded byte so both cases share a token.
    if (lc >= CHAR_W'(97) && lc <= CHAR_W'(122)) begin
      tok = TOKEN_W'(lc - CHAR_W'(97)) + TOKEN_W'(TOK_ALPHA_A);
    end else if (ch >= CHAR_W'(48) && ch <= CHAR_W'(57)) begin
      tok = TOKEN_W'(ch - CHAR_W'(48)) + TOKEN_W'(TOK_DIGIT0);
    end
  end

endmodule

// File: rtl/hdc_msg_tokenizer.sv
// Assembles a byte stream into a fixed-size lower-cased message plus token
// vector, truncating overlong messages, and holds it until downstream accepts.
//
// Handshakes: a beat transfers on a rising edge where in_valid && in_ready;
// a message transfers where out_valid && out_ready. Producers must hold
// their payload stable while valid is high and ready is low.
module hdc_msg_tokenizer #(
  parameter int MAX_LENGTH    = hdc_pkg::MAX_LENGTH,
  parameter int BITS_PER_CHAR = 8,
  parameter int TOK_W         = hdc_pkg::TOK_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BITS_PER_CHAR-1:0]          in_char,
  input  logic                              in_last,
  input  logic [1:0]                        in_label,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [MAX_LENGTH*BITS_PER_CHAR-1:0] msg,
  output logic [MAX_LENGTH*TOK_W-1:0]       tokens,
  output logic [7:0]                        length,
  output logic [1:0]                        label,
  output logic                              overflow,
  output logic [1:0]                        fsm_state
);

  hdc_pkg::state_t                    state;
  logic [7:0]                         wr_ptr;
  logic [MAX_LENGTH*BITS_PER_CHAR-1:0] msg_q;
  logic [MAX_LENGTH*TOK_W-1:0]        tok_q;
  logic [1:0]                         label_q;
  logic                               overflow_q;
  logic [BITS_PER_CHAR-1:0]           lc_char;
  logic [TOK_W-1:0]                   tok_char;
  logic                               accept;

  hdc_char_map #(
    .CHAR_W  (BITS_PER_CHAR),
    .TOKEN_W (TOK_W)
  ) u_char_map (
    .ch  (in_char),
    .lc  (lc_char),
    .tok (tok_char)
  );

  // Both ready and valid are decoded straight from the state register.
  assign in_ready  = (state != hdc_pkg::HOLD);
  assign out_valid = (state == hdc_pkg::HOLD);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= hdc_pkg::COLLECT;
      wr_ptr     <= 8'd0;
      msg_q      <= '0;
      tok_q      <= '0;
      label_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        hdc_pkg::COLLECT: begin
          if (accept) begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
              if (wr_ptr == 8'(i)) begin
                msg_q[BITS_PER_CHAR*i +: BITS_PER_CHAR] <= lc_char;
                tok_q[TOK_W*i +: TOK_W]                 <= tok_char;
              end
            end
            wr_ptr <= wr_ptr + 8'd1;
            if (in_last) begin
              label_q <= in_label;
              state   <= hdc_pkg::HOLD;
            end else if (wr_ptr == 8'(MAX_LENGTH - 1)) begin
              overflow_q <= 1'b1;
              state      <= hdc_pkg::DRAIN;
            end
          end
        end
        hdc_pkg::DRAIN: begin
          // Excess characters are swallowed; only the terminating label matters.
          if (accept && in_last) begin
            label_q <= in_label;
            state   <= hdc_pkg::HOLD;
          end
        end
        hdc_pkg::HOLD: begin
          if (out_ready) begin
            state      <= hdc_pkg::COLLECT;
            wr_ptr     <= 8'd0;
            msg_q      <= '0;
            tok_q      <= '0;
            label_q    <= 2'd0;
            overflow_q <= 1'b0;
          end
        end
        default: state <= hdc_pkg::COLLECT;
      endcase
    end
  end

  assign msg       = msg_q;
  assign tokens    = tok_q;
  assign length    = wr_ptr;
  assign label     = label_q;
  assign overflow  = overflow_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_hdc_msg_tokenizer.sv
// Self-checking bench for hdc_msg_tokenizer: per-byte mapping table, then
// multi-beat messages covering truncation, exact fill, output stall and reset.
module tb_hdc_msg_tokenizer;

  localparam int ML = 160;
  localparam int TW = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_char;
  logic             in_last;
  logic [1:0]       in_label;
  logic             out_valid;
  logic             out_ready;
  logic [ML*8-1:0]  msg;
  logic [ML*TW-1:0] tokens;
  logic [7:0]       length;
  logic [1:0]       label;
  logic             overflow;
  logic [1:0]       fsm_state;

  always #5 clk = ~clk;

  hdc_msg_tokenizer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .in_last   (in_last),
    .in_label  (in_label),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .msg       (msg),
    .tokens    (tokens),
    .length    (length),
    .label     (label),
    .overflow  (overflow),
    .fsm_state (fsm_state)
  );

  typedef struct packed {
    logic [ML*8-1:0]  msg;
    logic [ML*TW-1:0] tok;
    logic [7:0]       len;
    logic [1:0]       lbl;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] lc;
    logic [5:0] tok;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vt[14];
  logic [7:0] mbuf[0:255];
  int         mlen;
  bit         ready_ok;
  bit         saw_drain;
  int         checks = 0;
  int         errors = 0;

  task automatic chk_w(input string name, input logic [1279:0] act, input logic [1279:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_lc(input logic [7:0] b);
    return (b >= 8'd65 && b <= 8'd90) ? b + 8'd32 : b;
  endfunction

  function automatic logic [5:0] ref_tok(input logic [7:0] b);
    string      alpha = "0123456789abcdefghijklmnopqrstuvwxyz";
    logic [7:0] l;
    l = ref_lc(b);
    for (int k = 0; k < 36; k++) begin
      if (alpha[k] == l) return 6'(k + 1);
    end
    return 6'd0;
  endfunction

  task automatic push_model(input logic [1:0] lbl);
    exp_t e;
    int   n;
    e = '0;
    n = (mlen > ML) ? ML : mlen;
    for (int i = 0; i < n; i++) begin
      e.msg[8*i +: 8]   = ref_lc(mbuf[i]);
      e.tok[TW*i +: TW] = ref_tok(mbuf[i]);
    end
    e.len = 8'(n);
    e.lbl = lbl;
    e.ovf = (mlen > ML);
    exp_q.push_back(e);
  endtask

  task automatic load_str(input string s);
    mlen = s.len();
    for (int k = 0; k < mlen; k++) mbuf[k] = s[k];
  endtask

  task automatic send_beat(input logic [7:0] c, input logic last, input logic [1:0] lbl);
    @(negedge clk);
    if (fsm_state == 2'd1) saw_drain = 1'b1;
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    in_label = lbl;
    if (in_ready !== 1'b1) ready_ok = 1'b0;
    @(posedge clk);
  endtask

  // Non-final beats carry the inverted label so a wrong sampling point shows.
  task automatic send_msg(input logic [1:0] lbl);
    ready_ok  = 1'b1;
    saw_drain = 1'b0;
    for (int i = 0; i < mlen; i++) begin
      send_beat(mbuf[i], (i == mlen - 1), (i == mlen - 1) ? lbl : ~lbl);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input string name, input int stall);
    exp_t e;
    int   w;
    bit   st;
    w = 0;
    while (!out_valid && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_latency"}, 32'(w), 32'd0);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
      return;
    end
    e = exp_q.pop_front();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk_w({name, "_msg"}, 1280'(msg), 1280'(e.msg));
    chk_w({name, "_tokens"}, 1280'(tokens), 1280'(e.tok));
    chk({name, "_length"}, 32'(length), 32'(e.len));
    chk({name, "_label"}, 32'(label), 32'(e.lbl));
    chk({name, "_overflow"}, 32'(overflow), 32'(e.ovf));
    st = 1'b1;
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_char   = 8'($urandom_range(0, 255));
      in_last   = 1'($urandom_range(0, 1));
      in_label  = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || msg !== e.msg || tokens !== e.tok ||
          length !== e.len || label !== e.lbl || overflow !== e.ovf) st = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (stall > 0) chk({name, "_hold_stable"}, 32'(st), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_released"}, {28'd0, out_valid, in_ready, overflow, 1'b0}, 32'b0100);
    chk({name, "_cleared_len"}, 32'(length), 32'd0);
    chk_w({name, "_cleared_buf"}, {msg, tokens[959:640]}, 1280'd0);
    chk_w({name, "_cleared_tok"}, 1280'(tokens), 1280'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'd0;
    in_last   = 1'b0;
    in_label  = 2'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("reset_state", 32'(fsm_state), 32'd0);
    chk("reset_ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
    chk("reset_len_lbl_ovf", {21'd0, length, label, overflow}, 32'd0);
    chk_w("reset_msg", 1280'(msg), 1280'd0);
    chk_w("reset_tokens", 1280'(tokens), 1280'd0);

    vt[0]  = '{8'd65,  8'd97,  6'd11};
    vt[1]  = '{8'd90,  8'd122, 6'd36};
    vt[2]  = '{8'd97,  8'd97,  6'd11};
    vt[3]  = '{8'd122, 8'd122, 6'd36};
    vt[4]  = '{8'd48,  8'd48,  6'd1};
    vt[5]  = '{8'd57,  8'd57,  6'd10};
    vt[6]  = '{8'd64,  8'd64,  6'd0};
    vt[7]  = '{8'd91,  8'd91,  6'd0};
    vt[8]  = '{8'd96,  8'd96,  6'd0};
    vt[9]  = '{8'd123, 8'd123, 6'd0};
    vt[10] = '{8'd47,  8'd47,  6'd0};
    vt[11] = '{8'd58,  8'd58,  6'd0};
    vt[12] = '{8'hC1,  8'hC1,  6'd0};
    vt[13] = '{8'd77,  8'd109, 6'd23};
    for (int i = 0; i < 14; i++) begin
      e = '0;
      e.msg[7:0] = vt[i].lc;
      e.tok[5:0] = vt[i].tok;
      e.len      = 8'd1;
      e.lbl      = 2'(i % 4);
      exp_q.push_back(e);
      mbuf[0] = vt[i].ch;
      mlen    = 1;
      send_msg(2'(i % 4));
      check_out($sformatf("map%0d", i), 0);
    end

    load_str("Hi 5!");
    e = '0;
    e.msg[39:0] = {8'h21, 8'h35, 8'h20, 8'h69, 8'h68};
    e.tok[29:0] = {6'd0, 6'd6, 6'd0, 6'd19, 6'd18};
    e.len       = 8'd5;
    e.lbl       = 2'd1;
    exp_q.push_back(e);
    send_msg(2'd1);
    check_out("hi5", 0);

    mlen = 200;
    for (int i = 0; i < mlen; i++) mbuf[i] = 8'($urandom_range(32, 126));
    push_model(2'd2);
    send_msg(2'd2);
    chk("long_ready", 32'(ready_ok), 32'd1);
    chk("long_drain", 32'(saw_drain), 32'd1);
    check_out("long", 0);

    mlen = 160;
    for (int i = 0; i < mlen; i++) mbuf[i] = 8'($urandom_range(32, 126));
    push_model(2'd3);
    send_msg(2'd3);
    chk("exact_no_drain", 32'(saw_drain), 32'd0);
    check_out("exact", 0);

    mlen = 20;
    for (int i = 0; i < mlen; i++) mbuf[i] = 8'($urandom_range(65, 90));
    push_model(2'd1);
    send_msg(2'd1);
    check_out("stall", 10);
    load_str("ab");
    push_model(2'd0);
    send_msg(2'd0);
    check_out("after_stall", 0);

    for (int i = 0; i < 7; i++) send_beat(8'($urandom_range(48, 122)), 1'b0, 2'd3);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_state", {22'd0, fsm_state, length}, 32'd0);
    chk("midreset_valid", {30'd0, in_ready, out_valid}, 32'b10);
    load_str("ok");
    push_model(2'd2);
    send_msg(2'd2);
    check_out("ok", 0);

    for (int r = 0; r < 6; r++) begin
      mlen = $urandom_range(1, 40);
      for (int i = 0; i < mlen; i++) mbuf[i] = 8'($urandom_range(0, 255));
      push_model(2'(r));
      send_msg(2'(r));
      check_out($sformatf("rand%0d", r), $urandom_range(0, 3));
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
